// File: rtl/slc3_mem_pkg.sv
// Shared types and default sizing for the SLC-3 memory/IO controller.
package slc3_mem_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_WAIT_CYC = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRAM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 CPU memory controller: SRAM access with programmable strobe width,
// plus one memory-mapped address that reads the switches and writes the hex nibbles.
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                SW_W     = 10,
  parameter int                N_HEX    = 4,
  parameter int                WAIT_CYC = DEF_WAIT_CYC,
  parameter logic [ADDR_W-1:0] IO_ADDR  = '1
) (
  input  logic                 Clk,
  input  logic                 Reset_al,
  input  logic                 Req,
  input  logic                 Req_WE,
  input  logic [ADDR_W-1:0]    Cpu_ADDR,
  input  logic [DATA_W-1:0]    Data_from_CPU,
  output logic [DATA_W-1:0]    Data_to_CPU,
  output logic                 Ready,
  output logic                 Busy,
  output logic [ADDR_W-1:0]    ADDR,
  output logic                 OE_n,
  output logic                 WE_n,
  output logic [DATA_W-1:0]    Data_to_SRAM,
  input  logic [DATA_W-1:0]    Data_from_SRAM,
  input  logic [SW_W-1:0]      SW,
  output logic [4*N_HEX-1:0]   Hex_nib
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       we_q;
  logic       is_io;
  logic       accept;
  logic       sram_last;

  assign is_io     = (Cpu_ADDR == IO_ADDR);
  assign accept    = (state == IDLE) && Req;
  assign sram_last = (state == SRAM) && (cnt == CNT_LAST);

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) state <= IDLE;
    else           state <= state_nxt;
  end

  // Strobes decode from registered state only, so an async reset releases them at once.
  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    Busy      = 1'b1;
    OE_n      = 1'b1;
    WE_n      = 1'b1;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Req) state_nxt = is_io ? DONE : SRAM;
      end
      SRAM: begin
        OE_n = we_q;
        WE_n = !we_q;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        Ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // IO accesses complete on the accepting edge, so they use the live request inputs.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      cnt          <= '0;
      we_q         <= 1'b0;
      ADDR         <= '0;
      Data_to_SRAM <= '0;
      Data_to_CPU  <= '0;
      Hex_nib      <= '0;
    end else begin
      if (accept) begin
        ADDR         <= Cpu_ADDR;
        we_q         <= Req_WE;
        Data_to_SRAM <= Data_from_CPU;
        if (is_io) begin
          if (Req_WE) Hex_nib     <= Data_from_CPU[4*N_HEX-1:0];
          else        Data_to_CPU <= DATA_W'(SW);
        end
      end
      if (state == SRAM) begin
        if (sram_last) begin
          cnt <= '0;
          if (!we_q) Data_to_CPU <= Data_from_SRAM;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Bench for slc3_mem_ctrl: three instances (WAIT_CYC = 0, 1, 2) share all inputs;
// each scenario watches the instance it targets and checks against a scoreboard.
module tb_slc3_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_al = 1'b0;
  logic        Req = 1'b0;
  logic        Req_WE = 1'b0;
  logic [15:0] Cpu_ADDR = '0;
  logic [15:0] Data_from_CPU = '0;
  logic [15:0] Data_from_SRAM = '0;
  logic [9:0]  SW = '0;

  logic [15:0] d2c [3];
  logic [15:0] addr [3];
  logic [15:0] dts [3];
  logic [15:0] hex [3];
  logic        rdy [3];
  logic        busy [3];
  logic        oe_n [3];
  logic        we_n [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          lat;
    int          oe;
    int          we;
    logic [15:0] d2c;
    logic [15:0] hex;
  } exp_t;

  typedef struct {
    int          lat;
    int          oe;
    int          we;
    logic [15:0] d2c;
    logic [15:0] hex;
    bit          addr_ok;
    logic        rdy_after;
    logic        busy_after;
  } res_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    slc3_mem_ctrl #(.WAIT_CYC(g)) dut (
      .Clk            (Clk),
      .Reset_al       (Reset_al),
      .Req            (Req),
      .Req_WE         (Req_WE),
      .Cpu_ADDR       (Cpu_ADDR),
      .Data_from_CPU  (Data_from_CPU),
      .Data_to_CPU    (d2c[g]),
      .Ready          (rdy[g]),
      .Busy           (busy[g]),
      .ADDR           (addr[g]),
      .OE_n           (oe_n[g]),
      .WE_n           (we_n[g]),
      .Data_to_SRAM   (dts[g]),
      .Data_from_SRAM (Data_from_SRAM),
      .SW             (SW),
      .Hex_nib        (hex[g])
    );
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Single-cycle request; observes instance i until Ready (bounded), then one cycle more.
  task automatic run_access(input int i, input logic we, input logic [15:0] a,
                            input logic [15:0] d, output res_t o);
    o.lat = -1; o.oe = 0; o.we = 0; o.d2c = 'x; o.hex = 'x; o.addr_ok = 1'b1;
    @(negedge Clk);
    Req = 1'b1; Req_WE = we; Cpu_ADDR = a; Data_from_CPU = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      Req = 1'b0;
      if (oe_n[i] === 1'b0) o.oe++;
      if (we_n[i] === 1'b0) o.we++;
      if (busy[i] === 1'b1 && (addr[i] !== a || dts[i] !== d)) o.addr_ok = 1'b0;
      if (rdy[i] === 1'b1) begin
        o.lat = c; o.d2c = d2c[i]; o.hex = hex[i];
        break;
      end
    end
    @(negedge Clk);
    o.rdy_after = rdy[i]; o.busy_after = busy[i];
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({oe_n[i], we_n[i], rdy[i], busy[i]} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b, expected 1100", i, {oe_n[i], we_n[i], rdy[i], busy[i]});
      end
      n_tests++;
      if ({addr[i], dts[i], d2c[i], hex[i]} !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got %h, expected 0", i, {addr[i], dts[i], d2c[i], hex[i]});
      end
    end
    @(negedge Clk);
    Reset_al = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({busy[i], rdy[i], d2c[i]} !== 18'h0) begin
        n_fail++;
        $display("FAIL post_reset_idle[%0d]: got %h, expected 0", i, {busy[i], rdy[i], d2c[i]});
      end
    end
  endtask

  task automatic test_sram_read();
    res_t o; exp_t e;
    Data_from_SRAM = 16'hBEEF;
    sb.push_back('{lat: 2, oe: 2, we: 0, d2c: 16'hBEEF, hex: 16'h0000});
    run_access(1, 1'b0, 16'h0123, 16'h0000, o);
    e = sb.pop_front();
    n_tests++;
    if (o.lat !== e.lat) begin n_fail++; $display("FAIL rd_latency: got %0d, expected %0d", o.lat, e.lat); end
    n_tests++;
    if (o.oe !== e.oe || o.we !== e.we) begin
      n_fail++; $display("FAIL rd_strobes: got oe=%0d we=%0d, expected oe=%0d we=%0d", o.oe, o.we, e.oe, e.we);
    end
    n_tests++;
    if (o.d2c !== e.d2c) begin n_fail++; $display("FAIL rd_data: got %h, expected %h", o.d2c, e.d2c); end
    n_tests++;
    if ({o.addr_ok, o.rdy_after, o.busy_after} !== 3'b100) begin
      n_fail++; $display("FAIL rd_handshake: got %b, expected 100", {o.addr_ok, o.rdy_after, o.busy_after});
    end
    idle(6);
  endtask

  task automatic test_sram_write();
    res_t o; exp_t e;
    sb.push_back('{lat: 1, oe: 0, we: 1, d2c: 16'hBEEF, hex: 16'h0000});
    run_access(0, 1'b1, 16'h0040, 16'hA5A5, o);
    e = sb.pop_front();
    n_tests++;
    if (o.lat !== e.lat) begin n_fail++; $display("FAIL wr_latency: got %0d, expected %0d", o.lat, e.lat); end
    n_tests++;
    if (o.oe !== e.oe || o.we !== e.we) begin
      n_fail++; $display("FAIL wr_strobes: got oe=%0d we=%0d, expected oe=%0d we=%0d", o.oe, o.we, e.oe, e.we);
    end
    n_tests++;
    if (o.d2c !== e.d2c) begin n_fail++; $display("FAIL wr_keeps_rdata: got %h, expected %h", o.d2c, e.d2c); end
    n_tests++;
    if ({o.addr_ok, o.rdy_after, o.busy_after} !== 3'b100) begin
      n_fail++; $display("FAIL wr_addr_data: got %b, expected 100", {o.addr_ok, o.rdy_after, o.busy_after});
    end
    idle(6);
  endtask

  task automatic test_io();
    res_t o; exp_t e;
    sb.push_back('{lat: 0, oe: 0, we: 0, d2c: 16'hBEEF, hex: 16'h1234});
    run_access(1, 1'b1, 16'hFFFF, 16'h1234, o);
    e = sb.pop_front();
    n_tests++;
    if (o.lat !== e.lat) begin n_fail++; $display("FAIL io_wr_latency: got %0d, expected %0d", o.lat, e.lat); end
    n_tests++;
    if (o.oe !== e.oe || o.we !== e.we) begin
      n_fail++; $display("FAIL io_wr_no_strobe: got oe=%0d we=%0d, expected 0 0", o.oe, o.we);
    end
    n_tests++;
    if (o.hex !== e.hex || o.d2c !== e.d2c) begin
      n_fail++; $display("FAIL io_wr_hex: got hex=%h d2c=%h, expected hex=%h d2c=%h", o.hex, o.d2c, e.hex, e.d2c);
    end
    idle(4);
    SW = 10'h3FF;
    sb.push_back('{lat: 0, oe: 0, we: 0, d2c: 16'h03FF, hex: 16'h1234});
    run_access(1, 1'b0, 16'hFFFF, 16'h0000, o);
    e = sb.pop_front();
    n_tests++;
    if (o.lat !== e.lat || o.oe !== e.oe || o.we !== e.we) begin
      n_fail++; $display("FAIL io_rd_timing: got lat=%0d oe=%0d we=%0d, expected 0 0 0", o.lat, o.oe, o.we);
    end
    n_tests++;
    if (o.d2c !== e.d2c || o.hex !== e.hex) begin
      n_fail++; $display("FAIL io_rd_sw: got d2c=%h hex=%h, expected d2c=%h hex=%h", o.d2c, o.hex, e.d2c, e.hex);
    end
    n_tests++;
    if ({o.addr_ok, o.rdy_after, o.busy_after} !== 3'b100) begin
      n_fail++; $display("FAIL io_rd_handshake: got %b, expected 100", {o.addr_ok, o.rdy_after, o.busy_after});
    end
    idle(6);
  endtask

  task automatic test_wait2_read();
    res_t o; exp_t e;
    Data_from_SRAM = 16'h5A5A;
    sb.push_back('{lat: 3, oe: 3, we: 0, d2c: 16'h5A5A, hex: 16'h1234});
    run_access(2, 1'b0, 16'h0200, 16'h0000, o);
    e = sb.pop_front();
    n_tests++;
    if (o.lat !== e.lat || o.oe !== e.oe) begin
      n_fail++; $display("FAIL w2_timing: got lat=%0d oe=%0d, expected lat=%0d oe=%0d", o.lat, o.oe, e.lat, e.oe);
    end
    n_tests++;
    if (o.d2c !== e.d2c || o.hex !== e.hex) begin
      n_fail++; $display("FAIL w2_data: got d2c=%h hex=%h, expected d2c=%h hex=%h", o.d2c, o.hex, e.d2c, e.hex);
    end
    idle(6);
  endtask

  task automatic test_busy_ignore();
    int pulses = 0; int first = -1; int wes = 0; bit a_ok = 1'b1;
    Data_from_SRAM = 16'h0F0F;
    @(negedge Clk);
    Req = 1'b1; Req_WE = 1'b0; Cpu_ADDR = 16'h0300; Data_from_CPU = 16'h0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (c == 0) begin
        Req_WE = 1'b1; Cpu_ADDR = 16'h0040; Data_from_CPU = 16'hFFFF;
      end else begin
        Req = 1'b0;
      end
      if (we_n[2] === 1'b0) wes++;
      if (busy[2] === 1'b1 && addr[2] !== 16'h0300) a_ok = 1'b0;
      if (rdy[2] === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    n_tests++;
    if (pulses !== 1 || first !== 3) begin
      n_fail++; $display("FAIL busy_ignore_ready: got %0d pulses first at %0d, expected 1 at 3", pulses, first);
    end
    n_tests++;
    if (wes !== 0 || a_ok !== 1'b1 || d2c[2] !== 16'h0F0F) begin
      n_fail++; $display("FAIL busy_ignore_access: got we=%0d addr_ok=%0d d2c=%h, expected 0 1 0f0f", wes, a_ok, d2c[2]);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    exp_t e; int pulses = 0; int oes = 0;
    Data_from_SRAM = 16'h1111;
    sb.push_back('{lat: 3, oe: 0, we: 0, d2c: 16'h1111, hex: 16'h1234});
    sb.push_back('{lat: 8, oe: 0, we: 0, d2c: 16'h1111, hex: 16'h1234});
    @(negedge Clk);
    Req = 1'b1; Req_WE = 1'b0; Cpu_ADDR = 16'h0400; Data_from_CPU = 16'h0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (c == 9) Req = 1'b0;
      if (oe_n[2] === 1'b0) oes++;
      if (rdy[2] === 1'b1) begin
        pulses++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_ready: got pulse at %0d, expected none", c);
        end else begin
          e = sb.pop_front();
          if (c !== e.lat || d2c[2] !== e.d2c) begin
            n_fail++; $display("FAIL b2b_ready: got cycle %0d d2c=%h, expected cycle %0d d2c=%h", c, d2c[2], e.lat, e.d2c);
          end
        end
      end
    end
    n_tests++;
    if (pulses !== 2 || oes !== 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses %0d oe cycles, expected 2 and 6", pulses, oes);
    end
    sb.delete();
    idle(4);
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge Clk);
    Req = 1'b1; Req_WE = 1'b1; Cpu_ADDR = 16'h0040; Data_from_CPU = 16'h7777;
    @(negedge Clk);
    Req = 1'b0;
    n_tests++;
    if (we_n[2] !== 1'b0) begin n_fail++; $display("FAIL abort_pre_we: got %b, expected 0", we_n[2]); end
    #2 Reset_al = 1'b0;
    #1;
    n_tests++;
    if ({we_n[2], oe_n[2], rdy[2], busy[2]} !== 4'b1100) begin
      n_fail++; $display("FAIL abort_ctrl: got %b, expected 1100", {we_n[2], oe_n[2], rdy[2], busy[2]});
    end
    n_tests++;
    if ({addr[2], dts[2], d2c[2], hex[2]} !== 64'h0) begin
      n_fail++; $display("FAIL abort_data: got %h, expected 0", {addr[2], dts[2], d2c[2], hex[2]});
    end
    @(negedge Clk);
    Reset_al = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) if (rdy[i] === 1'b1 || we_n[i] === 1'b0) pulses++;
    end
    n_tests++;
    if (pulses !== 0 || d2c[2] !== 16'h0 || hex[2] !== 16'h0) begin
      n_fail++; $display("FAIL abort_no_ready: got %0d events d2c=%h hex=%h, expected 0 0 0", pulses, d2c[2], hex[2]);
    end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_wait2_read();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
